bla_sub16: RTL

BLA_SUB16 -- requirements
Module: bla_sub16

---
 rtl/bla_pkg.sv | 5 +
 rtl/bla4.sv | 21 ++
 rtl/bla_sub16.sv | 87 ++++++++
 3 files changed

// File: rtl/bla_pkg.sv
// bla_pkg: shared FSM state encoding and nibble width for the nibble-serial subtractor.
package bla_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/bla4.sv
// bla4: combinational 4-bit borrow-lookahead subtract slice, d = a - b - bin.
module bla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    assign g = ~a & b;
    assign p = ~(a ^ b);
    // Every borrow expanded from bin so all four resolve in parallel.
    assign c = {g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | (&p[2:0]) & bin,
                g[1] | p[1] & g[0] | p[1] & p[0] & bin,
                g[0] | p[0] & bin,
                bin};
    assign bout = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | (&p[3:1]) & g[0] | (&p) & bin;
    assign d = a ^ b ^ c;
endmodule

// File: rtl/bla_sub16.sv
// bla_sub16: nibble-serial W-bit subtractor with valid/ready handshake, one bla4 reused per nibble.
// Defining BLA_SUB16_OVF_EN adds the signed-overflow output V.
module bla_sub16
    import bla_pkg::*;
#(
    parameter int W   = 16,
    parameter int NIB = W / 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] D,
    output logic         Bout
`ifdef BLA_SUB16_OVF_EN
    ,
    output logic         V
`endif
);
    localparam int KW = NIB > 1 ? $clog2(NIB) : 1;
    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  d_q;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [KW-1:0] k;
    logic          brw;
    logic [3:0]    nd;
    logic          nb;
    logic          accept;
    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign a_sh      = a_q >> (NIBBLE_W * k);
    assign b_sh      = b_q >> (NIBBLE_W * k);
    assign D         = d_q;
    assign Bout      = brw;
    bla4 u_bla4 (
        .a   (a_sh[NIBBLE_W-1:0]),
        .b   (b_sh[NIBBLE_W-1:0]),
        .bin (brw),
        .d   (nd),
        .bout(nb)
    );
`ifdef BLA_SUB16_OVF_EN
    logic v_q;
    assign V = v_q;
`endif
    // D fills from the top so nibble 0 lands in the low bits after NIB steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            d_q   <= '0;
            k     <= '0;
            brw   <= 1'b0;
`ifdef BLA_SUB16_OVF_EN
            v_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            brw   <= Bin;
            k     <= '0;
            state <= BUSY;
        end else if (state == BUSY) begin
            d_q <= W'({nd, d_q} >> NIBBLE_W);
            brw <= nb;
            k   <= k + 1'b1;
            if (k == KW'(NIB - 1)) begin
                state <= DONE;
`ifdef BLA_SUB16_OVF_EN
                v_q   <= (a_q[W-1] ^ b_q[W-1]) & (nd[3] ^ a_q[W-1]);
`endif
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end
endmodule
